// File: rtl/fetch_request_unit.sv
// fetch_request_unit
// Instruction-fetch front end feeding the fetch-to-decode pipeline register.
// Owns the PC, keeps at most one instruction-memory read in flight, parks one
// response in a hold buffer while decode stalls, applies redirects (dropping
// wrong-path responses) and tags the next delivered instruction with a
// pending interrupt.
//
// Memory handshake: a request is offered while i_mem_read=1 and is accepted
// on the rising edge where i_mem_ready=1. Exactly one response follows, on
// the rising edge where i_mem_valid=1. i_mem_address equals the PC and only
// moves while i_mem_read=1 when a redirect is taken.

module fetch_request_unit #(
   parameter int                      DATA_WIDTH   = 32,
   parameter int                      ADDRESS_BITS = 20,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_BITS-1:0] program_address,
   input  logic                    stall,
   input  logic                    redirect_valid,
   input  logic [ADDRESS_BITS-1:0] redirect_target,
   input  logic                    interrupt_request,
   output logic                    i_mem_read,
   output logic [ADDRESS_BITS-1:0] i_mem_address,
   input  logic                    i_mem_ready,
   input  logic                    i_mem_valid,
   input  logic [DATA_WIDTH-1:0]   i_mem_data_in,
   output logic [DATA_WIDTH-1:0]   instruction_fetch,
   output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
   output logic                    interrupt_trigger_fetch,
   output logic [2:0]              debug_state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_REQUEST = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_DISCARD = 3'd4;

   localparam logic [DATA_WIDTH-1:0]   NOP    = DATA_WIDTH'(32'h0000_0013);
   localparam logic [ADDRESS_BITS-1:0] PC_INC = ADDRESS_BITS'(4);

   logic [2:0]              state_q, state_d;
   logic [ADDRESS_BITS-1:0] pc_q, pc_d;
   logic                    pending_q, pending_d;
   logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
   logic [ADDRESS_BITS-1:0] hold_pc_q, hold_pc_d;
   logic [DATA_WIDTH-1:0]   instr_q, instr_d;
   logic [ADDRESS_BITS-1:0] inst_pc_q, inst_pc_d;
   logic                    trig_q, trig_d;

   logic                    redirect_act;
   logic                    load_real;
   logic [DATA_WIDTH-1:0]   load_data;
   logic [ADDRESS_BITS-1:0] load_pc;

   // Redirects only mean something once fetching has started.
   assign redirect_act = redirect_valid && (state_q != S_IDLE);

   // Pick the real instruction (if any) that enters the output registers this edge.
   always_comb begin
      load_real = 1'b0;
      load_data = i_mem_data_in;
      load_pc   = pc_q;
      if (!redirect_act && !stall) begin
         if (state_q == S_WAIT && i_mem_valid) begin
            load_real = 1'b1;
            load_data = i_mem_data_in;
            load_pc   = pc_q;
         end else if (state_q == S_HOLD) begin
            load_real = 1'b1;
            load_data = hold_data_q;
            load_pc   = hold_pc_q;
         end
      end
   end

   // Fetch FSM, PC and hold buffer next-state.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hold_data_d = hold_data_q;
      hold_pc_d   = hold_pc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = program_address;
               state_d = S_REQUEST;
            end
         end
         S_REQUEST: begin
            if (redirect_act) begin
               pc_d    = redirect_target;
               // An accepted request still owes us a response, which is wrong-path.
               state_d = i_mem_ready ? S_DISCARD : S_REQUEST;
            end else if (i_mem_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_act) begin
               pc_d    = redirect_target;
               state_d = i_mem_valid ? S_REQUEST : S_DISCARD;
            end else if (i_mem_valid) begin
               pc_d = pc_q + PC_INC;
               if (stall) begin
                  hold_data_d = i_mem_data_in;
                  hold_pc_d   = pc_q;
                  state_d     = S_HOLD;
               end else begin
                  state_d = S_REQUEST;
               end
            end
         end
         S_HOLD: begin
            if (redirect_act) begin
               // Buffered instruction is wrong-path; leaving HOLD discards it.
               pc_d    = redirect_target;
               state_d = S_REQUEST;
            end else if (!stall) begin
               state_d = S_REQUEST;
            end
         end
         S_DISCARD: begin
            if (redirect_act) begin
               pc_d    = redirect_target;
               state_d = S_DISCARD;
            end else if (i_mem_valid) begin
               state_d = S_REQUEST;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output pipeline register and interrupt-pending next-state.
   always_comb begin
      instr_d   = instr_q;
      inst_pc_d = inst_pc_q;
      trig_d    = trig_q;
      if (redirect_act) begin
         instr_d = NOP;
         trig_d  = 1'b0;
      end else if (load_real) begin
         instr_d   = load_data;
         inst_pc_d = load_pc;
         trig_d    = pending_q;
      end else if (!stall) begin
         instr_d = NOP;
         trig_d  = 1'b0;
      end
      // A delivered real instruction consumes the pending interrupt; a fresh
      // request on the same edge re-arms it for the following instruction.
      pending_d = interrupt_request || (pending_q && !load_real);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         pending_q   <= 1'b0;
         hold_data_q <= '0;
         hold_pc_q   <= '0;
         instr_q     <= NOP;
         inst_pc_q   <= '0;
         trig_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pending_q   <= pending_d;
         hold_data_q <= hold_data_d;
         hold_pc_q   <= hold_pc_d;
         instr_q     <= instr_d;
         inst_pc_q   <= inst_pc_d;
         trig_q      <= trig_d;
      end
   end

   assign i_mem_read              = (state_q == S_REQUEST);
   assign i_mem_address           = pc_q;
   assign instruction_fetch       = instr_q;
   assign inst_PC_fetch           = inst_pc_q;
   assign interrupt_trigger_fetch = trig_q;
   assign debug_state             = state_q;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed bench for fetch_request_unit: hand-driven memory handshake,
// expected values written out per cycle.

module tb_fetch_request_unit;

   localparam int          DW    = 32;
   localparam int          AW    = 20;
   localparam logic [19:0] RPC   = 20'h00040;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] program_address;
   logic          stall;
   logic          redirect_valid;
   logic [AW-1:0] redirect_target;
   logic          interrupt_request;
   logic          i_mem_read;
   logic [AW-1:0] i_mem_address;
   logic          i_mem_ready;
   logic          i_mem_valid;
   logic [DW-1:0] i_mem_data_in;
   logic [DW-1:0] instruction_fetch;
   logic [AW-1:0] inst_PC_fetch;
   logic          interrupt_trigger_fetch;
   logic [2:0]    debug_state;

   int total = 0;
   int bad   = 0;

   fetch_request_unit #(
      .DATA_WIDTH  (DW),
      .ADDRESS_BITS(AW),
      .RESET_PC    (RPC)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .start                  (start),
      .program_address        (program_address),
      .stall                  (stall),
      .redirect_valid         (redirect_valid),
      .redirect_target        (redirect_target),
      .interrupt_request      (interrupt_request),
      .i_mem_read             (i_mem_read),
      .i_mem_address          (i_mem_address),
      .i_mem_ready            (i_mem_ready),
      .i_mem_valid            (i_mem_valid),
      .i_mem_data_in          (i_mem_data_in),
      .instruction_fetch      (instruction_fetch),
      .inst_PC_fetch          (inst_PC_fetch),
      .interrupt_trigger_fetch(interrupt_trigger_fetch),
      .debug_state            (debug_state)
   );

   // Clock.
   always #5 clock = ~clock;

   // Instruction word stored at an address (distinct per address, never NOP).
   function automatic logic [31:0] mem_word(input logic [19:0] a);
      return {12'hA5C, a};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs set before the call are sampled at that edge,
   // outputs are read 1 ns after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      start             = 1'b0;
      stall             = 1'b0;
      redirect_valid    = 1'b0;
      interrupt_request = 1'b0;
      i_mem_ready       = 1'b0;
      i_mem_valid       = 1'b0;
      i_mem_data_in     = '0;
   endtask

   task automatic restart(input logic [19:0] addr);
      reset = 1'b0;
      idle_inputs();
      step();
      step();
      reset           = 1'b1;
      start           = 1'b1;
      program_address = addr;
      step();
      start = 1'b0;
   endtask

   // Accept the current request, then return its data on the next edge.
   task automatic fetch_one(input logic [19:0] addr);
      i_mem_ready = 1'b1;
      step();
      i_mem_ready   = 1'b0;
      i_mem_valid   = 1'b1;
      i_mem_data_in = mem_word(addr);
      step();
      i_mem_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      program_address = '0;
      redirect_target = '0;
      idle_inputs();

      // ---- reset state ----
      step();
      check_val("rst_instr", instruction_fetch, NOP);
      check_val("rst_pcf", 32'(inst_PC_fetch), 32'h0);
      check_val("rst_trig", 32'(interrupt_trigger_fetch), 32'h0);
      check_val("rst_read", 32'(i_mem_read), 32'h0);
      check_val("rst_addr", 32'(i_mem_address), 32'(RPC));
      check_val("rst_state", 32'(debug_state), 32'h0);

      // ---- zero-wait stream from 0x100 ----
      restart(20'h00100);
      check_val("start_read", 32'(i_mem_read), 32'h1);
      check_val("start_addr", 32'(i_mem_address), 32'h100);
      for (int i = 0; i < 3; i++) begin
         logic [19:0] a;
         a = 20'h00100 + 20'(4 * i);
         i_mem_ready = 1'b1;
         step();
         i_mem_ready = 1'b0;
         check_val("zw_wait_read", 32'(i_mem_read), 32'h0);
         if (i > 0) check_val("zw_nop", instruction_fetch, NOP);
         i_mem_valid   = 1'b1;
         i_mem_data_in = mem_word(a);
         step();
         i_mem_valid = 1'b0;
         check_val("zw_instr", instruction_fetch, mem_word(a));
         check_val("zw_pcf", 32'(inst_PC_fetch), 32'(a));
         check_val("zw_next_addr", 32'(i_mem_address), 32'(a + 20'h4));
      end

      // ---- stall during response: HOLD then single release ----
      restart(20'h00100);
      fetch_one(20'h00100);
      i_mem_ready = 1'b1;
      step();
      i_mem_ready   = 1'b0;
      stall         = 1'b1;
      i_mem_valid   = 1'b1;
      i_mem_data_in = mem_word(20'h00104);
      step();
      i_mem_valid = 1'b0;
      check_val("hold_read0", 32'(i_mem_read), 32'h0);
      check_val("hold_state", 32'(debug_state), 32'h3);
      check_val("hold_instr0", instruction_fetch, NOP);
      check_val("hold_pcf0", 32'(inst_PC_fetch), 32'h100);
      step();
      step();
      check_val("hold_read2", 32'(i_mem_read), 32'h0);
      check_val("hold_pcf2", 32'(inst_PC_fetch), 32'h100);
      stall = 1'b0;
      step();
      check_val("rel_instr", instruction_fetch, mem_word(20'h00104));
      check_val("rel_pcf", 32'(inst_PC_fetch), 32'h104);
      check_val("rel_read", 32'(i_mem_read), 32'h1);
      check_val("rel_addr", 32'(i_mem_address), 32'h108);
      // stall again with a real instruction on the outputs: it must freeze
      stall       = 1'b1;
      i_mem_ready = 1'b1;
      step();
      i_mem_ready = 1'b0;
      check_val("frz_instr", instruction_fetch, mem_word(20'h00104));
      stall         = 1'b0;
      i_mem_valid   = 1'b1;
      i_mem_data_in = mem_word(20'h00108);
      step();
      i_mem_valid = 1'b0;
      check_val("after_frz_pcf", 32'(inst_PC_fetch), 32'h108);

      // ---- redirect while waiting: late response dropped ----
      restart(20'h00100);
      i_mem_ready = 1'b1;
      step();
      i_mem_ready     = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 20'h00200;
      step();
      redirect_valid = 1'b0;
      check_val("rdw_read", 32'(i_mem_read), 32'h0);
      check_val("rdw_instr", instruction_fetch, NOP);
      step();
      i_mem_valid   = 1'b1;
      i_mem_data_in = mem_word(20'h00100);
      step();
      i_mem_valid = 1'b0;
      check_val("rdw_drop", instruction_fetch, NOP);
      check_val("rdw_read2", 32'(i_mem_read), 32'h1);
      check_val("rdw_addr", 32'(i_mem_address), 32'h200);
      fetch_one(20'h00200);
      check_val("rdw_pcf", 32'(inst_PC_fetch), 32'h200);
      check_val("rdw_data", instruction_fetch, mem_word(20'h00200));

      // ---- redirect with response and stall on the same edge ----
      restart(20'h00100);
      fetch_one(20'h00100);
      stall       = 1'b1;
      i_mem_ready = 1'b1;
      step();
      i_mem_ready = 1'b0;
      check_val("rds_frozen", instruction_fetch, mem_word(20'h00100));
      i_mem_valid     = 1'b1;
      i_mem_data_in   = mem_word(20'h00104);
      redirect_valid  = 1'b1;
      redirect_target = 20'h00300;
      step();
      i_mem_valid    = 1'b0;
      redirect_valid = 1'b0;
      stall          = 1'b0;
      check_val("rds_nop", instruction_fetch, NOP);
      check_val("rds_trig", 32'(interrupt_trigger_fetch), 32'h0);
      check_val("rds_read", 32'(i_mem_read), 32'h1);
      check_val("rds_addr", 32'(i_mem_address), 32'h300);
      step();
      check_val("rds_nobuf", instruction_fetch, NOP);
      fetch_one(20'h00300);
      check_val("rds_pcf", 32'(inst_PC_fetch), 32'h300);

      // ---- redirect in REQUEST without acceptance ----
      restart(20'h00100);
      redirect_valid  = 1'b1;
      redirect_target = 20'h00400;
      step();
      redirect_valid = 1'b0;
      check_val("rdr_read", 32'(i_mem_read), 32'h1);
      check_val("rdr_addr", 32'(i_mem_address), 32'h400);

      // ---- interrupt tags next real instruction only ----
      restart(20'h00100);
      interrupt_request = 1'b1;
      step();
      interrupt_request = 1'b0;
      check_val("irq_nop_trig", 32'(interrupt_trigger_fetch), 32'h0);
      i_mem_ready = 1'b1;
      step();
      i_mem_ready = 1'b0;
      check_val("irq_wait_trig", 32'(interrupt_trigger_fetch), 32'h0);
      i_mem_valid   = 1'b1;
      i_mem_data_in = mem_word(20'h00100);
      step();
      i_mem_valid = 1'b0;
      check_val("irq_tag", 32'(interrupt_trigger_fetch), 32'h1);
      check_val("irq_tag_pcf", 32'(inst_PC_fetch), 32'h100);
      i_mem_ready = 1'b1;
      step();
      i_mem_ready = 1'b0;
      check_val("irq_after_nop", 32'(interrupt_trigger_fetch), 32'h0);
      i_mem_valid   = 1'b1;
      i_mem_data_in = mem_word(20'h00104);
      step();
      i_mem_valid = 1'b0;
      check_val("irq_once", 32'(interrupt_trigger_fetch), 32'h0);

      // ---- PC wrap and asynchronous reset mid-WAIT ----
      restart(20'hFFFFC);
      fetch_one(20'hFFFFC);
      check_val("wrap_pcf", 32'(inst_PC_fetch), 32'hFFFFC);
      check_val("wrap_addr", 32'(i_mem_address), 32'h0);
      stall       = 1'b1;
      i_mem_ready = 1'b1;
      step();
      i_mem_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_val("arst_instr", instruction_fetch, NOP);
      check_val("arst_pcf", 32'(inst_PC_fetch), 32'h0);
      check_val("arst_read", 32'(i_mem_read), 32'h0);
      check_val("arst_addr", 32'(i_mem_address), 32'(RPC));
      step();
      reset         = 1'b1;
      stall         = 1'b0;
      i_mem_valid   = 1'b1;
      i_mem_data_in = mem_word(20'h00000);
      step();
      i_mem_valid = 1'b0;
      check_val("late_instr", instruction_fetch, NOP);
      check_val("late_read", 32'(i_mem_read), 32'h0);
      check_val("late_state", 32'(debug_state), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
